// File: rtl/counter_prog.sv
// Programmable N-bit up/down counter with limit, wrap/saturate, load/clear, tc pulse, sticky ovf.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN (adds the presc port).
module counter_prog #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  mode_sat,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc,
`endif
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  ovf
);

  if (WIDTH < 2 || PRESCALE_W == 0) begin : g_param_check
    $error("counter_prog: WIDTH must be >= 2 and PRESCALE_W >= 1");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_boundary;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  presc_hit;

  assign presc_hit = (pcnt_q == presc);
  assign step      = en && presc_hit;

  always_comb begin
    pcnt_d = pcnt_q;
    if (clear || load) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = presc_hit ? '0 : pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`else
  assign step = en;
`endif

  // Up boundary uses >= so a load above limit still wraps/saturates instead of running on.
  assign at_boundary = up ? (out_q >= limit) : (out_q == '0);

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clear) begin
      out_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      out_d = load_val;
    end else if (step) begin
      if (at_boundary) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (!mode_sat) begin
          out_d = up ? '0 : limit;
        end
      end else begin
        out_d = up ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_prog.sv
// Self-checking bench for counter_prog: directed scenarios plus random stimulus vs a reference model.
// Honours COUNTER_PRESCALE_EN the same way the design does.
module tb_counter_prog;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en, up, mode_sat, clear, load;
  logic [W-1:0]  limit, load_val;
  logic [PW-1:0] presc;
  logic [W-1:0]  out;
  logic          tc, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int m_out, m_tc, m_ovf, m_pcnt;

  always #5 clk = ~clk;

  counter_prog #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .mode_sat (mode_sat),
    .limit    (limit),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
`ifdef COUNTER_PRESCALE_EN
    .presc    (presc),
`endif
    .out      (out),
    .tc       (tc),
    .ovf      (ovf)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Next count from the written rules, using plain integers.
  task automatic model_update();
    bit do_step;
    if (clear) begin
      m_out = 0; m_ovf = 0; m_tc = 0; m_pcnt = 0;
    end else if (load) begin
      m_out = int'(load_val); m_tc = 0; m_pcnt = 0;
    end else begin
      m_tc = 0;
      do_step = en;
`ifdef COUNTER_PRESCALE_EN
      if (en) begin
        if (m_pcnt == int'(presc)) m_pcnt = 0;
        else begin m_pcnt = m_pcnt + 1; do_step = 0; end
      end
`endif
      if (do_step) begin
        if (up) begin
          if (m_out >= int'(limit)) begin
            m_tc = 1; m_ovf = 1;
            if (!mode_sat) m_out = 0;
          end else m_out = m_out + 1;
        end else begin
          if (m_out == 0) begin
            m_tc = 1; m_ovf = 1;
            if (!mode_sat) m_out = int'(limit);
          end else m_out = m_out - 1;
        end
      end
    end
  endtask

  // One clock: predict, clock, compare #1 after the edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_eq("out", int'(out), m_out);
    check_eq("tc",  int'(tc),  m_tc);
    check_eq("ovf", int'(ovf), m_ovf);
  endtask

  task automatic set_idle();
    en = 0; clear = 0; load = 0;
  endtask

  task automatic do_load(input int v);
    set_idle(); load = 1; load_val = W'(v);
    tick();
    load = 0;
  endtask

  initial begin
    reset = 1'b0; en = 0; up = 1; mode_sat = 0; clear = 0; load = 0;
    limit = '1; load_val = '0; presc = '0;
    m_out = 0; m_tc = 0; m_ovf = 0; m_pcnt = 0;
    #1;
    check_eq("rst_out", int'(out), 0);
    check_eq("rst_tc",  int'(tc),  0);
    check_eq("rst_ovf", int'(ovf), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // 1: async reset mid-count, then count from 0
    do_load(7);
    check_eq("t1_loaded", int'(out), 7);
    #3 reset = 1'b0; en = 1;
    #1;
    check_eq("t1_async_out", int'(out), 0);
    check_eq("t1_async_tc",  int'(tc),  0);
    check_eq("t1_async_ovf", int'(ovf), 0);
    m_out = 0; m_tc = 0; m_ovf = 0; m_pcnt = 0;
    @(posedge clk); #1;
    check_eq("t1_held", int'(out), 0);
    #2 reset = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("t1_count", int'(out), i);
    end

    // 2: up wrap at limit 3
    set_idle(); clear = 1; tick(); clear = 0;
    limit = 3; up = 1; mode_sat = 0; en = 1;
    begin
      int exp_o[5] = '{1, 2, 3, 0, 1};
      int exp_t[5] = '{0, 0, 0, 1, 0};
      int exp_v[5] = '{0, 0, 0, 1, 1};
      for (int i = 0; i < 5; i++) begin
        tick();
        check_eq("t2_out", int'(out), exp_o[i]);
        check_eq("t2_tc",  int'(tc),  exp_t[i]);
        check_eq("t2_ovf", int'(ovf), exp_v[i]);
      end
    end

    // 3: saturate up then down
    set_idle(); clear = 1; tick(); clear = 0;
    limit = 3; up = 1; mode_sat = 1; en = 1;
    begin
      int exp_o[5] = '{1, 2, 3, 3, 3};
      int exp_t[5] = '{0, 0, 0, 1, 1};
      for (int i = 0; i < 5; i++) begin
        tick();
        check_eq("t3u_out", int'(out), exp_o[i]);
        check_eq("t3u_tc",  int'(tc),  exp_t[i]);
      end
    end
    up = 0;
    begin
      int exp_o[5] = '{2, 1, 0, 0, 0};
      int exp_t[5] = '{0, 0, 0, 1, 1};
      for (int i = 0; i < 5; i++) begin
        tick();
        check_eq("t3d_out", int'(out), exp_o[i]);
        check_eq("t3d_tc",  int'(tc),  exp_t[i]);
      end
    end
    check_eq("t3_ovf", int'(ovf), 1);

    // 4: clear beats load; then load above limit wraps on next step
    set_idle(); clear = 1; load = 1; load_val = 9; tick();
    check_eq("t4_clr_out", int'(out), 0);
    check_eq("t4_clr_ovf", int'(ovf), 0);
    limit = 5; up = 1; mode_sat = 0;
    do_load(9);
    check_eq("t4_load", int'(out), 9);
    en = 1; tick();
    check_eq("t4_wrap_out", int'(out), 0);
    check_eq("t4_wrap_tc",  int'(tc),  1);

    // 5: down wrap reloads limit
    limit = 4; up = 0; mode_sat = 0;
    do_load(1);
    en = 1;
    begin
      int exp_o[3] = '{0, 4, 3};
      int exp_t[3] = '{0, 1, 0};
      for (int i = 0; i < 3; i++) begin
        tick();
        check_eq("t5_out", int'(out), exp_o[i]);
        check_eq("t5_tc",  int'(tc),  exp_t[i]);
      end
    end

`ifdef COUNTER_PRESCALE_EN
    // 6: prescaler period 3 with an enable gap
    set_idle(); clear = 1; tick(); clear = 0;
    limit = '1; up = 1; mode_sat = 0; presc = 2; en = 1;
    begin
      int exp_o[6] = '{0, 0, 1, 1, 1, 2};
      for (int i = 0; i < 6; i++) begin
        tick();
        check_eq("t6_out", int'(out), exp_o[i]);
      end
    end
    tick();
    check_eq("t6_mid", int'(out), 2);
    en = 0; tick(); tick();
    check_eq("t6_gap", int'(out), 2);
    en = 1; tick();
    check_eq("t6_res1", int'(out), 2);
    tick();
    check_eq("t6_res2", int'(out), 3);
    presc = 0;
`endif

    // Random phase
    for (int i = 0; i < 1500; i++) begin
      clear    = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 14) == 0);
      load_val = W'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) == 1;
      mode_sat = ($urandom_range(0, 2) == 0);
      limit    = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      presc    = PW'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
